fifo_prog: RTL

Parametrised synchronous FIFO, next generation of the team's 16x8 FIFO. It adds arbitrary (non-power-of-2) depth, an occupancy count, run-time programmable almost-full/almost-empty thresholds, a synchronous flush, and a selectable standard or first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer and keeps the existing wr_ack/overflow/underflow handshake flags.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_prog_if.sv | 38 +++
 rtl/fifo_mem.sv | 25 ++
 rtl/fifo_prog.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable FIFO.
package fifo_pkg;

  // Read-port behaviour: registered standard read or first-word-fall-through
  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_mode_e;

  // Width needed to hold an occupancy value in the range 0..depth
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_prog_if.sv
// Producer/consumer bundle for fifo_prog; clock and reset are kept outside.
interface fifo_prog_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = fifo_pkg::cnt_w(FIFO_DEPTH);

  logic                  flush;
  logic                  wr_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;

  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(FIFO_DEPTH)-1:0] wr_addr,
  input  logic [FIFO_WIDTH-1:0]         wr_data,
  input  logic [$clog2(FIFO_DEPTH)-1:0] rd_addr,
  output logic [FIFO_WIDTH-1:0]         rd_data
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  // Contents are never cleared; pointers alone decide what is valid
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, flush and STD/FWFT read modes.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int         FIFO_WIDTH = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter fifo_mode_e MODE       = FIFO_STD
) (
  input logic        clk,
  input logic        rst,
  fifo_prog_if.slave bus
);

  localparam int CNT_W  = cnt_w(FIFO_DEPTH);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full_c;
  logic                  empty_c;
  logic                  wr_go;
  logic                  rd_go;
  logic                  mem_we;
  logic [FIFO_WIDTH-1:0] rd_data;

  // Explicit wrap so that non-power-of-2 depths work
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_W'(1);
  endfunction

  assign full_c  = (count_q == DEPTH_CNT);
  assign empty_c = (count_q == '0);

  // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside a read
  assign rd_go  = bus.rd_en & ~empty_c;
  assign wr_go  = bus.wr_en & (~full_c | rd_go);
  assign mem_we = wr_go & ~bus.flush & ~rst;

  fifo_mem #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (mem_we),
    .wr_addr(wr_ptr),
    .wr_data(bus.data_in),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  // Pointer and occupancy tracking; flush empties the FIFO exactly like reset
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_go) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({wr_go, rd_go})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // One-cycle handshake pulses reporting what happened to last cycle's requests
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_go;
      overflow_q  <= bus.wr_en & ~wr_go;
      underflow_q <= bus.rd_en & ~rd_go;
    end
  end

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.count       = count_q;
  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.almostfull  = (count_q >= bus.af_thresh);
  assign bus.almostempty = (count_q <= bus.ae_thresh);

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;
      logic                  rvalid_q;

      // Registered read: data appears the cycle after an accepted read; flush keeps the last word
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q   <= '0;
          rvalid_q <= 1'b0;
        end else if (bus.flush) begin
          rvalid_q <= 1'b0;
        end else if (rd_go) begin
          dout_q   <= rd_data;
          rvalid_q <= 1'b1;
        end else begin
          rvalid_q <= 1'b0;
        end
      end

      assign bus.data_out = dout_q;
      assign bus.rd_valid = rvalid_q;
    end else begin : g_fwft
      assign bus.data_out = rd_data;
      assign bus.rd_valid = ~empty_c;
    end
  endgenerate

endmodule
